// File: rtl/palette_lookup_arbiter_if.sv
// Bus bundle between the sprite pixel fetchers, the shared palette ROM and the
// compositor. The arbiter sits on the slave side. The master side is the
// surrounding fabric, which drives the requests, the palette colour and the
// compositor's rsp_ready.
interface palette_lookup_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 4,
    parameter int RGB_W   = 12
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ*IDX_W-1:0] req_index;
    logic [NUM_REQ-1:0]       req_ready;
    logic [IDX_W-1:0]         pal_index;
    logic [RGB_W-1:0]         pal_rgb;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [RGB_W-1:0]         rsp_rgb;
    logic                     rsp_transparent;

    modport master (
        output req_valid, req_last, req_index, pal_rgb, rsp_ready,
        input  req_ready, pal_index, rsp_valid, rsp_id, rsp_rgb, rsp_transparent
    );

    modport slave (
        input  req_valid, req_last, req_index, pal_rgb, rsp_ready,
        output req_ready, pal_index, rsp_valid, rsp_id, rsp_rgb, rsp_transparent
    );
endinterface

// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter that shares one combinational sprite palette between
// several pixel fetchers. Once a fetcher wins, it keeps the palette until its
// burst ends or it reaches BURST_MAX lookups. Each accepted lookup lands in a
// single response register. That register carries the requester ID and a
// transparency flag for the compositor.
module palette_lookup_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = 4,
    parameter int RGB_W      = 12,
    parameter int TRANSP_IDX = 0,
    parameter int BURST_MAX  = 32
) (
    input logic                     Clk,
    input logic                     Reset_n,
    palette_lookup_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t            state_r;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [ID_W-1:0]   owner_r;
    logic [CNT_W-1:0]  burst_cnt_r;
    logic              rsp_valid_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic [RGB_W-1:0]  rsp_rgb_r;
    logic              rsp_transparent_r;

    logic              can_issue_s;
    logic              winner_found_s;
    logic [ID_W-1:0]   winner_id_s;
    logic [ID_W-1:0]   cand_s;
    logic              grant_s;
    logic [ID_W-1:0]   grant_id_s;
    logic [ID_W-1:0]   sel_id_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              burst_full_s;

    // Round-robin successor, wrapping from the last requester back to 0.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        logic [ID_W-1:0] nxt;
        if (id == ID_W'(NUM_REQ - 1)) begin
            nxt = {ID_W{1'b0}};
        end else begin
            nxt = id + ID_W'(1);
        end
        return nxt;
    endfunction

    assign can_issue_s  = !rsp_valid_r || bus.rsp_ready;
    assign cnt_next_s   = (burst_cnt_r == {CNT_W{1'b1}}) ? burst_cnt_r : burst_cnt_r + CNT_W'(1);
    assign burst_full_s = (cnt_next_s >= CNT_W'(BURST_MAX));

    // Find the first valid requester, starting the search at the round-robin pointer.
    always_comb begin
        winner_found_s = 1'b0;
        winner_id_s    = {ID_W{1'b0}};
        cand_s         = {ID_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = ID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (!winner_found_s && bus.req_valid[cand_s]) begin
                winner_found_s = 1'b1;
                winner_id_s    = cand_s;
            end else begin
                winner_found_s = winner_found_s;
            end
        end
    end

    // Pick the grant for this cycle. A locked burst admits only its owner.
    always_comb begin
        grant_s    = 1'b0;
        grant_id_s = owner_r;
        if (!Reset_n) begin
            grant_s = 1'b0;
        end else begin
            case (state_r)
                ST_ARB: begin
                    grant_s    = winner_found_s && can_issue_s;
                    grant_id_s = winner_id_s;
                end
                ST_LOCK: begin
                    grant_s    = bus.req_valid[owner_r] && can_issue_s;
                    grant_id_s = owner_r;
                end
                default: begin
                    grant_s    = 1'b0;
                    grant_id_s = owner_r;
                end
            endcase
        end
    end

    // Drive the one-hot ready vector and steer the granted (or owner's) index to the palette.
    always_comb begin
        bus.req_ready = {NUM_REQ{1'b0}};
        sel_id_s      = grant_s ? grant_id_s : owner_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s && (grant_id_s == ID_W'(i))) begin
                bus.req_ready[i] = 1'b1;
            end else begin
                bus.req_ready[i] = 1'b0;
            end
        end
        bus.pal_index = bus.req_index[sel_id_s*IDX_W +: IDX_W];
    end

    // Arbitration FSM together with the registered response stage.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r           <= ST_ARB;
            rr_ptr_r          <= {ID_W{1'b0}};
            owner_r           <= {ID_W{1'b0}};
            burst_cnt_r       <= {CNT_W{1'b0}};
            rsp_valid_r       <= 1'b0;
            rsp_id_r          <= {ID_W{1'b0}};
            rsp_rgb_r         <= {RGB_W{1'b0}};
            rsp_transparent_r <= 1'b0;
        end else begin
            if (grant_s) begin
                rsp_valid_r       <= 1'b1;
                rsp_id_r          <= grant_id_s;
                rsp_rgb_r         <= bus.pal_rgb;
                rsp_transparent_r <= (bus.pal_index == IDX_W'(TRANSP_IDX));
            end else if (bus.rsp_ready && rsp_valid_r) begin
                rsp_valid_r <= 1'b0;
            end

            case (state_r)
                ST_ARB: begin
                    if (grant_s) begin
                        owner_r     <= grant_id_s;
                        burst_cnt_r <= CNT_W'(1);
                        if (bus.req_last[grant_id_s] || (BURST_MAX <= 1)) begin
                            rr_ptr_r <= next_id(grant_id_s);
                        end else begin
                            state_r <= ST_LOCK;
                        end
                    end
                end
                ST_LOCK: begin
                    if (grant_s) begin
                        burst_cnt_r <= cnt_next_s;
                        if (bus.req_last[owner_r] || burst_full_s) begin
                            state_r  <= ST_ARB;
                            rr_ptr_r <= next_id(owner_r);
                        end
                    end
                end
                default: begin
                    state_r <= ST_ARB;
                end
            endcase
        end
    end

    assign bus.rsp_valid       = rsp_valid_r;
    assign bus.rsp_id          = rsp_id_r;
    assign bus.rsp_rgb         = rsp_rgb_r;
    assign bus.rsp_transparent = rsp_transparent_r;
endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter. Directed scenarios and random traffic are
// both checked against a transaction-level model of grants and responses.
module tb_palette_lookup_arbiter;
    localparam int NR   = 4;
    localparam int IW   = 4;
    localparam int RW   = 12;
    localparam int BMAX = 32;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    palette_lookup_arbiter_if #(.NUM_REQ(NR), .IDX_W(IW), .RGB_W(RW)) intf ();

    palette_lookup_arbiter #(
        .NUM_REQ(NR), .IDX_W(IW), .RGB_W(RW), .TRANSP_IDX(0), .BURST_MAX(BMAX)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(intf.slave)
    );

    logic [RW-1:0] pal_mem [16];
    always_comb intf.pal_rgb = pal_mem[intf.pal_index];

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    bit          m_locked;
    int          m_owner, m_ptr, m_cnt;
    bit          m_rsp_valid;
    int          m_rsp_id;
    logic [11:0] m_rsp_rgb;
    bit          m_rsp_tr;
    int          obs_grant;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int oh2id(input logic [NR-1:0] r);
        for (int i = 0; i < NR; i++) begin
            if (r == (NR'(1) << i)) return i;
        end
        return -1;
    endfunction

    function automatic int predict_grant(input logic [NR-1:0] v, input logic rr);
        if (m_rsp_valid && !rr) return -1;
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < NR; k++) begin
            if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_rsp_valid = 0; m_rsp_id = 0; m_rsp_rgb = 12'h000; m_rsp_tr = 0;
    endtask

    // One clock cycle: drive inputs, check against the model, clock, then advance the model.
    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] l,
                        input logic [NR*IW-1:0] idx, input logic rr);
        int g;
        int sel;
        logic [IW-1:0] sel_idx;
        intf.req_valid = v;
        intf.req_last  = l;
        intf.req_index = idx;
        intf.rsp_ready = rr;
        #2;
        g   = predict_grant(v, rr);
        sel = (g >= 0) ? g : m_owner;
        check_value("req_ready", 32'(intf.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check_value("pal_index", 32'(intf.pal_index), 32'(idx[sel*IW +: IW]));
        check_value("rsp_valid", 32'(intf.rsp_valid), 32'(m_rsp_valid));
        if (m_rsp_valid) begin
            check_value("rsp_id", 32'(intf.rsp_id), 32'(m_rsp_id));
            check_value("rsp_rgb", 32'(intf.rsp_rgb), 32'(m_rsp_rgb));
            check_value("rsp_transparent", 32'(intf.rsp_transparent), 32'(m_rsp_tr));
        end
        obs_grant = oh2id(intf.req_ready);
        @(posedge Clk);
        if (g >= 0) begin
            sel_idx     = idx[g*IW +: IW];
            m_rsp_valid = 1;
            m_rsp_id    = g;
            m_rsp_rgb   = pal_mem[sel_idx];
            m_rsp_tr    = (sel_idx == 4'd0);
            if (!m_locked) begin
                m_owner = g;
                m_cnt   = 1;
                if (l[g] || m_cnt >= BMAX) m_ptr = (g + 1) % NR;
                else m_locked = 1;
            end else begin
                m_cnt++;
                if (l[g] || m_cnt >= BMAX) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % NR;
                end
            end
        end else if (rr) begin
            m_rsp_valid = 0;
        end
        #1;
    endtask

    // Assert reset while requests are pending, check that it blocks grants, then release it between edges.
    task automatic do_reset();
        Reset_n = 1'b0;
        intf.req_valid = 4'hF;
        intf.req_last  = 4'h0;
        intf.rsp_ready = 1'b1;
        #1;
        check_value("reset_req_ready", 32'(intf.req_ready), 32'd0);
        check_value("reset_rsp_valid", 32'(intf.rsp_valid), 32'd0);
        @(posedge Clk);
        #2;
        check_value("reset_rsp_rgb", 32'(intf.rsp_rgb), 32'd0);
        intf.req_valid = 4'h0;
        Reset_n = 1'b1;
        model_reset();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int exp_order[$];
        int got_order[$];
        int cnt0;
        bit seen1;
        Reset_n = 1'b0;
        intf.req_valid = 4'h0;
        intf.req_last  = 4'h0;
        intf.req_index = 16'h0000;
        intf.rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) pal_mem[i] = 12'($urandom);
        pal_mem[0] = 12'h6DF;
        pal_mem[5] = 12'hA53;
        model_reset();
        #3;
        do_reset();

        // single request from 2 with index 5
        step(4'b0100, 4'b0100, 16'h0500, 1'b1);
        check_value("single_grant", 32'(obs_grant), 32'd2);
        check_value("single_rsp_valid", 32'(intf.rsp_valid), 32'd1);
        check_value("single_rsp_id", 32'(intf.rsp_id), 32'd2);
        check_value("single_rsp_rgb", 32'(intf.rsp_rgb), 32'hA53);
        check_value("single_rsp_transp", 32'(intf.rsp_transparent), 32'd0);
        step(4'hF, 4'hF, 16'($urandom), 1'b1);
        check_value("ptr_after_single", 32'(obs_grant), 32'd3);

        // all valid, one-beat bursts: plain rotation
        do_reset();
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 4'hF, 16'($urandom), 1'b1);
            check_value("rotation", 32'(obs_grant), 32'(exp_order[i]));
        end

        // burst of 8 from 1 while 0 and 3 wait
        do_reset();
        step(4'b0001, 4'b0001, 16'h0000, 1'b1);
        exp_order = '{1, 1, 1, 1, 1, 1, 1, 1, 3, 0};
        got_order.delete();
        for (int b = 0; b < 10; b++) begin
            step({1'b1, 1'b0, (b < 8), 1'b1}, {1'b1, 1'b0, (b == 7), 1'b1}, 16'($urandom), 1'b1);
            got_order.push_back(obs_grant);
        end
        for (int i = 0; i < 10; i++) check_value("burst8_order", 32'(got_order[i]), 32'(exp_order[i]));

        // endless burst from 0 is cut off at BURST_MAX
        do_reset();
        cnt0 = 0;
        seen1 = 0;
        for (int b = 0; b < 40; b++) begin
            step(4'b0011, 4'b0010, 16'($urandom), 1'b1);
            if (obs_grant == 1) seen1 = 1;
            if (obs_grant == 0 && !seen1) cnt0++;
        end
        check_value("forced_rotation_cnt", 32'(cnt0), 32'(BMAX));
        check_value("forced_rotation_1", 32'(seen1), 32'd1);

        // compositor stall for three cycles
        do_reset();
        step(4'b0001, 4'b0001, 16'h0003, 1'b1);
        for (int s = 0; s < 3; s++) begin
            step(4'b0001, 4'b0001, 16'h0004, 1'b0);
            check_value("stall_no_grant", 32'(obs_grant), 32'hFFFF_FFFF);
        end
        step(4'b0001, 4'b0001, 16'h0004, 1'b1);
        check_value("stall_resume", 32'(obs_grant), 32'd0);
        step(4'b0001, 4'b0001, 16'h0006, 1'b1);
        check_value("stall_resume2", 32'(obs_grant), 32'd0);

        // transparent key colour
        step(4'b0001, 4'b0001, 16'h0000, 1'b1);
        check_value("transp_flag", 32'(intf.rsp_transparent), 32'd1);
        check_value("transp_rgb", 32'(intf.rsp_rgb), 32'h6DF);
        step(4'b0000, 4'b0000, 16'h0000, 1'b1);

        // reset in the middle of a locked burst
        do_reset();
        for (int b = 0; b < 3; b++) step(4'b0001, 4'b0000, 16'($urandom), 1'b1);
        check_value("midlock_before", 32'(intf.rsp_valid), 32'd1);
        #1;
        do_reset();
        step(4'b0010, 4'b0010, 16'h0070, 1'b1);
        check_value("midlock_after", 32'(obs_grant), 32'd1);

        // random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step(4'($urandom), 4'($urandom & $urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
